// File: rtl/pw_pattern_match.sv
// Trigger qualification: compares the leading N bytes of each sniffed USB packet
// against a masked pattern and emits a one-cycle match pulse, once per arm.
module pw_pattern_match #(
  parameter int pPATTERN_BYTES = 8,
  parameter int pCOUNT_WIDTH   = 4
) (
  input  logic                          fe_clk,
  input  logic                          reset_i,
  input  logic                          I_arm,
  input  logic [8*pPATTERN_BYTES-1:0]   I_pattern,
  input  logic [8*pPATTERN_BYTES-1:0]   I_mask,
  input  logic [pCOUNT_WIDTH-1:0]       I_pattern_bytes,
  input  logic                          I_rxactive,
  input  logic [7:0]                    I_sniff_data,
  input  logic                          I_sniff_wr,
  output logic                          O_match,
  output logic                          O_armed,
  output logic [2:0]                    O_state
);

  localparam int IW = (pPATTERN_BYTES > 1) ? $clog2(pPATTERN_BYTES) : 1;
  localparam logic [pCOUNT_WIDTH-1:0] NMAX = pCOUNT_WIDTH'(pPATTERN_BYTES);

  typedef enum logic [2:0] {
    IDLE = 3'd0, SYNC = 3'd1, WAIT_PKT = 3'd2, COMPARE = 3'd3, SKIP = 3'd4, DONE = 3'd5
  } state_t;

  state_t                                state_q, state_d;
  logic [pCOUNT_WIDTH-1:0]               idx_q, idx_d, n_q, n_cap;
  logic [pPATTERN_BYTES-1:0][7:0]        pat_q, msk_q;
  logic                                  match_q, match_d, armed_q, armed_d;
  logic [pCOUNT_WIDTH-1:0]               cur_idx;
  logic [7:0]                            cur_pat, cur_msk;
  logic                                  hit, last;

  assign n_cap = (I_pattern_bytes > NMAX) ? NMAX : I_pattern_bytes;

  // A packet's first byte may arrive in the same cycle rxactive rises, so WAIT_PKT compares as index 0.
  assign cur_idx = (state_q == WAIT_PKT) ? '0 : idx_q;
  assign cur_pat = pat_q[cur_idx[IW-1:0]];
  assign cur_msk = msk_q[cur_idx[IW-1:0]];
  assign hit     = (n_q == '0) || (((I_sniff_data ^ cur_pat) & cur_msk) == 8'h00);
  assign last    = (n_q == '0) || (cur_idx == n_q - pCOUNT_WIDTH'(1));

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      pat_q   <= '0;
      msk_q   <= '0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      armed_q <= armed_d;
      if (state_q == IDLE && I_arm) begin
        n_q   <= n_cap;
        pat_q <= I_pattern;
        msk_q <= I_mask;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!I_arm) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SYNC;
          idx_d   = '0;
        end
        SYNC:     if (!I_rxactive) state_d = WAIT_PKT;
        WAIT_PKT, COMPARE: begin
          if (!I_rxactive) begin
            state_d = WAIT_PKT;
          end else begin
            state_d = COMPARE;
            idx_d   = cur_idx;
            if (I_sniff_wr) begin
              if (!hit)      state_d = SKIP;
              else if (last) state_d = DONE;
              else           idx_d   = cur_idx + pCOUNT_WIDTH'(1);
            end
          end
        end
        SKIP:     if (!I_rxactive) state_d = WAIT_PKT;
        DONE:     state_d = DONE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    match_d = (state_d == DONE) && (state_q != DONE);
    armed_d = (state_d == WAIT_PKT) || (state_d == COMPARE) || (state_d == SKIP);
  end

  assign O_match = match_q;
  assign O_armed = armed_q;
  assign O_state = state_q;

endmodule

// File: tb/tb_pw_pattern_match.sv
// Bench for pw_pattern_match: directed scenarios then random traffic, all
// checked cycle by cycle against a flag-based packet model.
module tb_pw_pattern_match;
  logic        clk = 1'b0;
  logic        rst = 1'b1, arm = 1'b0, rx = 1'b0, wr = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [63:0] pat = '0, msk = '0;
  logic [3:0]  nb = 4'd0;
  logic        o_match, o_armed;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  pw_pattern_match #(.pPATTERN_BYTES(8), .pCOUNT_WIDTH(4)) dut (
    .fe_clk(clk), .reset_i(rst), .I_arm(arm), .I_pattern(pat), .I_mask(msk),
    .I_pattern_bytes(nb), .I_rxactive(rx), .I_sniff_data(data), .I_sniff_wr(wr),
    .O_match(o_match), .O_armed(o_armed), .O_state(o_state)
  );

  int npass = 0, ntot = 0, npulse = 0;

  // model: armed-since-arm, seen an idle gap, inside a packet, bytes matched, mismatch seen, fired
  bit          m_on, m_sync, m_inpkt, m_bad, m_done, m_match;
  int          m_cnt, m_n;
  logic [63:0] m_pat, m_msk;

  function automatic logic [2:0] m_state();
    if (!m_on)    return 3'd0;
    if (!m_sync)  return 3'd1;
    if (m_done)   return 3'd5;
    if (!m_inpkt) return 3'd2;
    if (m_bad)    return 3'd4;
    return 3'd3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_byte();
    if (wr && rx && !m_bad) begin
      if (m_n == 0 || ((data ^ m_pat[8*m_cnt +: 8]) & m_msk[8*m_cnt +: 8]) == 8'h00) begin
        m_cnt++;
        if (m_cnt >= m_n) begin
          m_done  = 1;
          m_match = 1;
        end
      end else m_bad = 1;
    end
  endtask

  task automatic model_step();
    m_match = 0;
    if (rst || !arm) begin
      m_on = 0; m_sync = 0; m_inpkt = 0; m_bad = 0; m_done = 0; m_cnt = 0;
    end else if (!m_on) begin
      m_on = 1; m_sync = 0; m_inpkt = 0; m_bad = 0; m_done = 0; m_cnt = 0;
      m_pat = pat; m_msk = msk; m_n = (nb > 4'd8) ? 8 : int'(nb);
    end else if (m_done) begin
      m_match = 0;
    end else if (!m_sync) begin
      if (!rx) m_sync = 1;
    end else if (!m_inpkt) begin
      if (rx) begin
        m_inpkt = 1; m_cnt = 0; m_bad = 0;
        model_byte();
      end
    end else if (!rx) begin
      m_inpkt = 0;
    end else begin
      model_byte();
    end
  endtask

  task automatic tick(input logic a, input logic r, input logic w, input logic [7:0] d);
    arm = a; rx = r; wr = w; data = d;
    model_step();
    @(posedge clk);
    #1;
    if (o_match) npulse++;
    check("match", 32'(o_match), 32'(m_match));
    check("state", 32'(o_state), 32'(m_state()));
    check("armed", 32'(o_armed), 32'(m_on && m_sync && !m_done));
  endtask

  task automatic send_pkt(input int len, input logic [63:0] b);
    tick(1, 1, 0, 8'h00);
    for (int i = 0; i < len; i++) tick(1, 1, 1, b[8*i +: 8]);
    tick(1, 0, 0, 8'h00);
    tick(1, 0, 0, 8'h00);
  endtask

  task automatic rearm();
    tick(0, 0, 0, 8'h00);
    tick(1, 0, 0, 8'h00);
    tick(1, 0, 0, 8'h00);
    npulse = 0;
  endtask

  initial begin
    logic a, r, w;
    logic [7:0] d;

    // reset
    rst = 1;
    tick(1, 1, 1, 8'h69);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_match", 32'(o_match), 32'd0);
    rst = 0;

    // 1: basic match
    pat = 64'hD269; msk = 64'hFFFF; nb = 4'd2;
    rearm();
    send_pkt(3, 64'h00D269);
    check("t1_pulses", 32'(npulse), 32'd1);
    check("t1_state", 32'(o_state), 32'd5);
    check("t1_armed", 32'(o_armed), 32'd0);

    // 2: mask
    pat = 64'h2D; msk = 64'h0F; nb = 4'd1;
    rearm();
    send_pkt(1, 64'hAD);
    check("t2_hit", 32'(npulse), 32'd1);
    rearm();
    send_pkt(1, 64'h2C);
    check("t2_miss", 32'(npulse), 32'd0);
    check("t2_state", 32'(o_state), 32'd2);

    // 3: arm while a packet is already streaming
    pat = 64'hD269; msk = 64'hFFFF; nb = 4'd2;
    tick(0, 1, 1, 8'h69);
    npulse = 0;
    tick(1, 1, 1, 8'h69);
    tick(1, 1, 1, 8'h69);
    tick(1, 1, 1, 8'hD2);
    tick(1, 1, 0, 8'h00);
    check("t3_sync", 32'(o_state), 32'd1);
    check("t3_nopulse", 32'(npulse), 32'd0);
    tick(1, 0, 0, 8'h00);
    send_pkt(2, 64'hD269);
    check("t3_pulse", 32'(npulse), 32'd1);

    // 4: short packet
    pat = 64'h13D269; nb = 4'd3;
    rearm();
    send_pkt(2, 64'hD269);
    check("t4_short", 32'(npulse), 32'd0);
    check("t4_state", 32'(o_state), 32'd2);
    send_pkt(3, 64'h13D269);
    check("t4_full", 32'(npulse), 32'd1);

    // 5: one-shot then re-arm
    rearm();
    send_pkt(3, 64'h13D269);
    send_pkt(3, 64'h13D269);
    check("t5_oneshot", 32'(npulse), 32'd1);
    tick(0, 0, 0, 8'h00);
    tick(1, 0, 0, 8'h00);
    tick(1, 0, 0, 8'h00);
    send_pkt(3, 64'h13D269);
    check("t5_rearm", 32'(npulse), 32'd2);

    // 6a: reset in COMPARE
    pat = 64'hD269; nb = 4'd2;
    rearm();
    tick(1, 1, 0, 8'h00);
    tick(1, 1, 1, 8'h69);
    check("t6_cmp", 32'(o_state), 32'd3);
    rst = 1;
    tick(1, 1, 1, 8'hD2);
    rst = 0;
    check("t6_rst_state", 32'(o_state), 32'd0);
    check("t6_rst_match", 32'(o_match), 32'd0);
    tick(1, 1, 0, 8'h00);
    tick(1, 0, 0, 8'h00);

    // 6b: disarm on the final matching byte
    rearm();
    tick(1, 1, 0, 8'h00);
    tick(1, 1, 1, 8'h69);
    tick(0, 1, 1, 8'hD2);
    tick(0, 0, 0, 8'h00);
    check("t6_drop", 32'(npulse), 32'd0);

    // 6c: N=9 behaves as 8
    pat = 64'h0807060504030201; msk = '1; nb = 4'd9;
    rearm();
    send_pkt(8, pat);
    check("t6_clamp", 32'(npulse), 32'd1);
    check("t6_clamp_st", 32'(o_state), 32'd5);

    // random traffic, biased toward matching bytes and short patterns
    msk = 64'hFF00FF0FFFFFFFFF;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) begin
        pat = {$urandom, $urandom};
        msk = {$urandom, $urandom} | {$urandom, $urandom};
        nb  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(0, 3));
      end
      a = ($urandom_range(0, 79) != 0);
      r = rx;
      if ($urandom_range(0, 6) == 0) r = ~rx;
      w = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 4) != 0 && m_cnt < 8) ? m_pat[8*m_cnt +: 8] : 8'($urandom);
      tick(a, r, w, d);
    end
    rst = 0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/pw_pattern_match.md
Name: pw_pattern_match

Overview:
- Trigger-qualification stage between the front-end sniff stream and pw_trigger.
- Watches bytes sniffed from the USB front end and compares the first N bytes of each received packet against a programmable byte pattern with a per-bit mask.
- On a full match it emits a single-cycle match pulse. That pulse feeds pw_trigger's I_match input, after the existing clock-domain handling in reg_pw.
- Runs entirely in the front-end clock domain.

Parameters:
- pPATTERN_BYTES, 8: maximum number of packet bytes compared.
- pCOUNT_WIDTH, 4: width of the byte-count input and index. Must be at least clog2(pPATTERN_BYTES+1).

Ports:
- fe_clk  input  1  front-end clock (60 MHz ULPI/UTMI clock); the only clock.
- reset_i  input  1  reset, synchronous, active-high.
- I_arm  input  1  level; 1 = armed, 0 = disarmed.
- I_pattern  input  8*pPATTERN_BYTES  pattern; byte k occupies bits [8k+7:8k].
- I_mask  input  8*pPATTERN_BYTES  per-bit compare enable; 1 = compare, 0 = don't care.
- I_pattern_bytes  input  pCOUNT_WIDTH  N, the number of leading packet bytes to compare.
- I_rxactive  input  1  front-end rxactive; high for the duration of a received packet.
- I_sniff_data  input  8  sniffed byte.
- I_sniff_wr  input  1  I_sniff_data valid this cycle.
- O_match  output  1  one-cycle match pulse.
- O_armed  output  1  high in WAIT_PKT, COMPARE and SKIP.
- O_state  output  3  state encoding, for debug readback.

Behaviour:
- Reset (reset_i sampled high on a fe_clk edge):
  - state = IDLE, byte index = 0.
  - O_match = 0, O_armed = 0, O_state = IDLE.
  - Reset has priority over every other event, including a packet in progress.
- Config inputs (I_pattern, I_mask, I_pattern_bytes):
  - Captured into internal registers on the cycle the block leaves IDLE.
  - Changes while armed are ignored until the next arm.
  - A captured N greater than pPATTERN_BYTES is clamped to pPATTERN_BYTES.
- Byte compare: byte k matches when ((I_sniff_data XOR pattern[k]) AND mask[k]) == 0.
- State encodings: IDLE=0, SYNC=1, WAIT_PKT=2, COMPARE=3, SKIP=4, DONE=5.
- Transitions:
  - I_arm low in any state → IDLE next cycle. This overrides all other transitions, including a match in the same cycle: no O_match is produced.
  - IDLE, I_arm high → SYNC. SYNC exists so the block never begins comparing mid-packet.
  - SYNC:
    - I_rxactive low → WAIT_PKT.
    - Otherwise stay in SYNC.
  - WAIT_PKT, I_rxactive high → COMPARE with index = 0.
    - If I_sniff_wr is also high in that cycle, that byte is compared as byte 0.
  - COMPARE, I_sniff_wr high:
    - Byte mismatch → SKIP.
    - Byte match with index == N-1 → DONE, and O_match = 1 on the next cycle.
    - Byte match otherwise → index + 1.
    - I_sniff_wr with I_rxactive low is ignored in every state.
  - COMPARE, I_rxactive low before N bytes have matched → WAIT_PKT, no match (short packet).
  - SKIP, I_rxactive low → WAIT_PKT.
  - DONE:
    - Stays until I_arm goes low. Matching is one-shot per arm.
    - O_armed = 0 in DONE.
- N = 0:
  - Matches on the first I_sniff_wr of the first packet after arming, regardless of data.
  - O_match follows one cycle later and the state goes to DONE.
- Latency: O_match is registered and high for exactly one cycle, the cycle after the fe_clk edge that sampled the final matching byte.
- Index arithmetic:
  - The index is pCOUNT_WIDTH bits and only ever increments in COMPARE.
  - It is bounded by N-1 ≤ pPATTERN_BYTES-1, so it never wraps.
- Back-to-back bytes (I_sniff_wr high on consecutive cycles) are supported, with no stall.
- O_armed and O_state are registered.

Test Plan:
1. Basic match:
   - Stimulus: reset; arm with N=2, pattern 0x..._D2_69, mask 0xFFFF; packet bytes 0x69, 0xD2, 0x00.
   - Required: exactly one O_match pulse, on the cycle after the 0xD2 write; state DONE; O_armed=0.
2. Mask:
   - Stimulus: N=1, pattern 0x2D, mask 0x0F; bytes 0xAD, then in a later packet 0x2C.
   - Required: match on 0xAD; 0x2C never matches.
3. Mid-packet arm:
   - Stimulus: I_rxactive already high with bytes 0x69 streaming when I_arm rises; next packet carries 0x69, 0xD2.
   - Required: no match during the first packet; match in the second packet.
4. Short packet:
   - Stimulus: N=3; packet 0x69, 0xD2, then I_rxactive falls.
   - Required: no O_match, state WAIT_PKT; the next full 3-byte matching packet produces a match.
5. One-shot and re-arm:
   - Stimulus: two matching packets while armed; then toggle I_arm 0→1; then a third matching packet.
   - Required: one pulse for the first two packets; a second pulse on the third packet.
6. Reset and overrides:
   - Stimulus: reset_i asserted during COMPARE; separately, I_arm dropped in the same cycle as the final matching byte; separately, N=9 programmed.
   - Required: reset → IDLE, O_match=0; I_arm drop → no pulse; N=9 clamped to 8.
